// File: rtl/parallel_decoder.sv
// Count code -> two MSB-first thermometer words (weights 8 and 1), driven as timed pulses.
// Optional PARALLEL_DECODER_SAT_EN: codes above 72 saturate to all-ones and pulse err_o.
module parallel_decoder #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [6:0] code_i,
    output logic [7:0] input_1_o,
    output logic [7:0] input_2_o,
    output logic       drive_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       err_o
);
    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       buf_valid;
    logic [6:0] buf_code;
    logic       pulse_last, gap_last, pop, push, oor;
    logic [3:0] n1, n2;

    function automatic logic [7:0] therm(input logic [3:0] n);
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) t[7-i] = (i < int'(n));
        return t;
    endfunction

    assign pulse_last = (state == DRIVE) && (cnt == PULSE_LAST);
    assign gap_last   = (state == GAP) && (cnt == GAP_LAST);
    // Buffer is drained on entry from IDLE, at the end of a gap, or back-to-back when no gap.
    assign pop        = buf_valid && ((state == IDLE) || (pulse_last && GAP_CYCLES == 0) || gap_last);
    assign in_ready_o = !buf_valid || pop;
    assign push       = in_valid_i && in_ready_o;
    assign busy_o     = (state != IDLE) || buf_valid;

    always_comb begin
        oor = buf_code > 7'd72;
        n1  = '0;
        n2  = '0;
        if (buf_code <= 7'd64) begin
            n1 = buf_code[6:3];
            n2 = {1'b0, buf_code[2:0]};
        end else if (!oor) begin
            n1 = 4'd8;
            n2 = 4'(buf_code - 7'd64);
        end else begin
`ifdef PARALLEL_DECODER_SAT_EN
            n1 = 4'd8;
            n2 = 4'd8;
`else
            n1 = 4'd0;
            n2 = 4'd0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            buf_valid <= 1'b0;
            buf_code  <= '0;
            input_1_o <= '0;
            input_2_o <= '0;
            drive_o   <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            done_o <= pulse_last;
`ifdef PARALLEL_DECODER_SAT_EN
            err_o  <= pop && oor;
`else
            err_o  <= 1'b0;
`endif
            if (push) begin
                buf_code  <= code_i;
                buf_valid <= 1'b1;
            end else if (pop) begin
                buf_valid <= 1'b0;
            end

            if (pop) begin
                input_1_o <= therm(n1);
                input_2_o <= therm(n2);
                drive_o   <= 1'b1;
                state     <= DRIVE;
                cnt       <= '0;
            end else begin
                case (state)
                    DRIVE: begin
                        if (pulse_last) begin
                            input_1_o <= '0;
                            input_2_o <= '0;
                            drive_o   <= 1'b0;
                            cnt       <= '0;
                            state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    GAP: begin
                        if (gap_last) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_parallel_decoder.sv
// Random-stimulus bench: three decoder instances (P/G = 4/1, 4/0, 1/3) checked every cycle
// against a pulse-schedule model (start = max(accept+2, prev_start+P+G)).
module tb_parallel_decoder;
`ifdef PARALLEL_DECODER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int NDIR = 10;
    localparam int N    = 210;

    logic       clk = 1'b0;
    logic       rst [3];
    logic       vld [3];
    logic       rdy [3];
    logic       drv [3];
    logic       dn  [3];
    logic       bsy [3];
    logic       er  [3];
    logic [6:0] cd  [3];
    logic [7:0] w1  [3];
    logic [7:0] w2  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        parallel_decoder #(
            .PULSE_CYCLES(g == 2 ? 1 : 4),
            .GAP_CYCLES  (g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk_i(clk), .rst_i(rst[g]), .in_valid_i(vld[g]), .in_ready_o(rdy[g]),
            .code_i(cd[g]), .input_1_o(w1[g]), .input_2_o(w2[g]), .drive_o(drv[g]),
            .done_o(dn[g]), .busy_o(bsy[g]), .err_o(er[g])
        );
    end

    int ntot = 0, npass = 0, cyc = 0;
    int codes [N];
    int pc [3][1024];
    int pa [3][1024];
    int ps [3][1024];
    int np [3];
    int idx [3];
    int t19 = -100, rc = -100;
    bit rst_done = 1'b0;

    function automatic int pl(int k); return (k == 2) ? 1 : 4; endfunction
    function automatic int gl(int k); return (k == 0) ? 1 : ((k == 1) ? 0 : 3); endfunction
    function automatic int therm(int n); return (255 << (8 - n)) & 255; endfunction
    function automatic int mn1(int code);
        if (code <= 64) return code / 8;
        if (code <= 72) return 8;
        return SAT ? 8 : 0;
    endfunction
    function automatic int mn2(int code);
        if (code <= 64) return code % 8;
        if (code <= 72) return code - 64;
        return SAT ? 8 : 0;
    endfunction

    task automatic chk(string nm, int k, int act, int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s inst%0d cyc %0d: got %0h want %0h", nm, k, cyc, act, exp);
    endtask

    function automatic bit buf_full(int k, int c);
        for (int i = np[k] - 1; i >= 0 && i >= np[k] - 4; i--)
            if (pa[k][i] < c && c < ps[k][i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit starts_at(int k, int c);
        for (int i = np[k] - 1; i >= 0 && i >= np[k] - 4; i--)
            if (ps[k][i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(int k, int c);
        return !buf_full(k, c) || starts_at(k, c + 1);
    endfunction

    task automatic check_inst(int k, int c);
        int e1, e2, ed, edn, eer, eb;
        e1 = 0; e2 = 0; ed = 0; edn = 0; eer = 0; eb = buf_full(k, c);
        for (int i = np[k] - 1; i >= 0 && i >= np[k] - 4; i--) begin
            if (ps[k][i] <= c && c < ps[k][i] + pl(k)) begin
                e1 = therm(mn1(pc[k][i]));
                e2 = therm(mn2(pc[k][i]));
                ed = 1;
            end
            if (ps[k][i] + pl(k) == c) edn = 1;
            if (SAT && ps[k][i] == c && pc[k][i] > 72) eer = 1;
            if (ps[k][i] <= c && c < ps[k][i] + pl(k) + gl(k)) eb = 1;
        end
        chk("input_1", k, int'(w1[k]), e1);
        chk("input_2", k, int'(w2[k]), e2);
        chk("drive", k, int'(drv[k]), ed);
        chk("done", k, int'(dn[k]), edn);
        chk("err", k, int'(er[k]), eer);
        chk("busy", k, int'(bsy[k]), eb);
        chk("in_ready", k, int'(rdy[k]), int'(m_ready(k, cyc)));
    endtask

    task automatic accept(int k, int c, int code);
        int s;
        s = c + 2;
        if (np[k] > 0 && ps[k][np[k]-1] + pl(k) + gl(k) > s) s = ps[k][np[k]-1] + pl(k) + gl(k);
        pc[k][np[k]] = code;
        pa[k][np[k]] = c;
        ps[k][np[k]] = s;
        np[k]++;
        idx[k]++;
    endtask

    initial begin
        int fin_cyc;
        int dir_list [NDIR];
        int sw [5];
        int sw1 [5];
        int sw2 [5];
        fin_cyc = -1;
        dir_list = '{19, 0, 8, 64, 65, 72, 100, 1, 2, 3};
        for (int i = 0; i < N; i++)
            codes[i] = (i < NDIR) ? dir_list[i] :
                       (($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 72)));
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; vld[k] = 1'b0; cd[k] = '0; np[k] = 0; idx[k] = 0;
        end

        // Hand-computed decode table pins the model.
        sw  = '{0, 8, 64, 65, 72};
        sw1 = '{'h00, 'h80, 'hFF, 'hFF, 'hFF};
        sw2 = '{'h00, 'h00, 'h00, 'h80, 'hFF};
        for (int i = 0; i < 5; i++) begin
            chk("model_w1", 0, therm(mn1(sw[i])), sw1[i]);
            chk("model_w2", 0, therm(mn2(sw[i])), sw2[i]);
        end
        chk("model_19", 0, (therm(mn1(19)) << 8) | therm(mn2(19)), 'hC0E0);
        chk("model_100", 0, therm(mn1(100)), SAT ? 'hFF : 'h00);

        while (cyc < 6000 && !(fin_cyc >= 0 && cyc > fin_cyc + 30)) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) check_inst(k, cyc);

            if (cyc == t19 + 2) begin
                chk("lit_w1_19", 0, int'(w1[0]), 'hC0);
                chk("lit_w2_19", 0, int'(w2[0]), 'hE0);
                chk("lit_drive_19", 0, int'(drv[0]), 1);
            end
            if (cyc == t19 + 5) chk("lit_drive_last", 0, int'(drv[0]), 1);
            if (cyc == t19 + 6) begin
                chk("lit_done", 0, int'(dn[0]), 1);
                chk("lit_drive_off", 0, int'(drv[0]), 0);
            end
            if (cyc == t19 + 7) chk("lit_busy_low", 0, int'(bsy[0]), 0);
            if (cyc == 1) chk("lit_reset_ready", 0, int'(rdy[0]), 1);
            if (cyc == rc + 1) begin
                chk("lit_rst_drive", 0, int'(drv[0]), 0);
                chk("lit_rst_w1", 0, int'(w1[0]), 0);
                chk("lit_rst_ready", 0, int'(rdy[0]), 1);
                chk("lit_rst_busy", 0, int'(bsy[0]), 0);
            end
            if (cyc == rc + 1 || cyc == rc + 2) chk("lit_rst_nodone", 0, int'(dn[0]), 0);

            for (int k = 0; k < 3; k++) begin
                rst[k] = 1'b0;
                vld[k] = 1'b0;
                if (cyc < 3) begin
                    rst[k] = 1'b1;
                end else if (k == 0 && !rst_done && idx[0] > 30 &&
                             starts_at(0, cyc - 1) && buf_full(0, cyc)) begin
                    rst[0] = 1'b1;
                    np[0] = 0;
                    rst_done = 1'b1;
                    rc = cyc;
                end else if (idx[k] < N && !(idx[k] == 1 && cyc < 20)) begin
                    if (idx[k] < NDIR || $urandom_range(0, 9) < 6) begin
                        vld[k] = 1'b1;
                        cd[k] = 7'(codes[idx[k]]);
                        if (m_ready(k, cyc)) begin
                            if (k == 0 && idx[k] == 0) t19 = cyc;
                            accept(k, cyc, codes[idx[k]]);
                        end
                    end
                end
            end
            if (fin_cyc < 0 && idx[0] == N && idx[1] == N && idx[2] == N) fin_cyc = cyc;
        end

        ntot++;
        if (fin_cyc >= 0 && rst_done) npass++;
        else $display("FAIL progress: finished=%0d reset_test=%0d want 1 1", fin_cyc >= 0, rst_done);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
